// File: rtl/rfg_framer_pkg.sv
// ---------------------------------------------------------------------------
// rfg_framer_pkg
// Shared types and helpers for the readback framer.
//   state_t              : framer FSM states
//   FRAME_HEADER_DEFAULT : default first byte of every frame
//   csum_add()           : 8-bit wrap-around add used for the frame checksum
// ---------------------------------------------------------------------------
package rfg_framer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_LENH,
        ST_LENL,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_DATA,
        ST_CSUM
    } state_t;

    localparam logic [7:0] FRAME_HEADER_DEFAULT = 8'hA5;

    function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/rfg_readback_framer.sv
// ---------------------------------------------------------------------------
// rfg_readback_framer
// Burst read engine and framer. One request (address, byte count, increment
// flag) produces single-byte register reads; the returned bytes are framed as
//   HEADER, ADDR, LEN[15:8], LEN[7:0], DATA x LEN, CSUM
// and written into the FTDI write FIFO, throttled by its prog_full flag.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   req_*              : request handshake (valid/ready), address, length, incr
//   rfg_read/address   : one-cycle read strobe and address to the register file
//   rfg_read_data/done : returned byte and completion pulse
//   fifo_din/wr_en     : byte and write strobe into the FIFO
//   fifo_prog_full     : FIFO near full; no byte or read is started while high
//   busy               : a frame is in progress
//   timeout_err        : sticky read-timeout flag, cleared on next acceptance
// ---------------------------------------------------------------------------
module rfg_readback_framer
    import rfg_framer_pkg::*;
#(
    parameter logic [7:0]  FRAME_HEADER = FRAME_HEADER_DEFAULT,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_address,
    input  logic [15:0] req_length,
    input  logic        req_incr,
    output logic        rfg_read,
    output logic [7:0]  rfg_address,
    input  logic [7:0]  rfg_read_data,
    input  logic        rfg_done,
    output logic [7:0]  fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_prog_full,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

    state_t      r_state;
    logic        r_req_ready;
    logic        r_rfg_read;
    logic [7:0]  r_rfg_address;
    logic [7:0]  r_fifo_din;
    logic        r_fifo_wr_en;
    logic        r_busy;
    logic        r_timeout_err;
    logic        r_incr;
    logic [15:0] r_length;
    logic [15:0] r_remaining;
    logic [7:0]  r_csum;
    logic [7:0]  r_data;
    logic [15:0] r_tmo_cnt;

    state_t      w_state_next;
    logic        w_req_ready_next;
    logic        w_rfg_read_next;
    logic [7:0]  w_rfg_address_next;
    logic [7:0]  w_fifo_din_next;
    logic        w_fifo_wr_en_next;
    logic        w_busy_next;
    logic        w_timeout_err_next;
    logic        w_incr_next;
    logic [15:0] w_length_next;
    logic [15:0] w_remaining_next;
    logic [7:0]  w_csum_next;
    logic [7:0]  w_data_next;
    logic [15:0] w_tmo_cnt_next;
    logic        w_accept;
    logic [15:0] w_tmo_inc;

    assign w_tmo_inc = r_tmo_cnt + 16'd1;

    always_comb begin
        w_state_next       = r_state;
        w_rfg_read_next    = 1'b0;
        w_rfg_address_next = r_rfg_address;
        w_fifo_din_next    = r_fifo_din;
        w_fifo_wr_en_next  = 1'b0;
        w_timeout_err_next = r_timeout_err;
        w_incr_next        = r_incr;
        w_length_next      = r_length;
        w_remaining_next   = r_remaining;
        w_csum_next        = r_csum;
        w_data_next        = r_data;
        w_tmo_cnt_next     = r_tmo_cnt;
        w_accept           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept           = 1'b1;
                    w_rfg_address_next = req_address;
                    w_length_next      = req_length;
                    w_incr_next        = req_incr;
                    w_csum_next        = 8'h00;
                    w_timeout_err_next = 1'b0;
                    w_state_next       = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!fifo_prog_full) begin
                    w_fifo_wr_en_next = 1'b1;
                    w_fifo_din_next   = FRAME_HEADER;
                    w_state_next      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // rfg_address still holds the start address here; it only
                // advances once data bytes are emitted.
                if (!fifo_prog_full) begin
                    w_fifo_wr_en_next = 1'b1;
                    w_fifo_din_next   = r_rfg_address;
                    w_csum_next       = csum_add(r_csum, r_rfg_address);
                    w_state_next      = ST_LENH;
                end
            end
            ST_LENH: begin
                if (!fifo_prog_full) begin
                    w_fifo_wr_en_next = 1'b1;
                    w_fifo_din_next   = r_length[15:8];
                    w_csum_next       = csum_add(r_csum, r_length[15:8]);
                    w_state_next      = ST_LENL;
                end
            end
            ST_LENL: begin
                if (!fifo_prog_full) begin
                    w_fifo_wr_en_next = 1'b1;
                    w_fifo_din_next   = r_length[7:0];
                    w_csum_next       = csum_add(r_csum, r_length[7:0]);
                    w_remaining_next  = r_length;
                    w_state_next      = (r_length == 16'd0) ? ST_CSUM : ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                // Reads are held off while the FIFO is near full so the
                // returned byte always has somewhere to go.
                if (!fifo_prog_full) begin
                    w_rfg_read_next = 1'b1;
                    w_tmo_cnt_next  = 16'd0;
                    w_state_next    = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (rfg_done) begin
                    w_data_next  = rfg_read_data;
                    w_state_next = ST_DATA;
                end else if (w_tmo_inc == TMO_LIMIT) begin
                    // Substitute a zero byte so the frame keeps its length.
                    w_data_next        = 8'h00;
                    w_timeout_err_next = 1'b1;
                    w_state_next       = ST_DATA;
                end else begin
                    w_tmo_cnt_next = w_tmo_inc;
                end
            end
            ST_DATA: begin
                if (!fifo_prog_full) begin
                    w_fifo_wr_en_next = 1'b1;
                    w_fifo_din_next   = r_data;
                    w_csum_next       = csum_add(r_csum, r_data);
                    w_remaining_next  = r_remaining - 16'd1;
                    if (r_incr) begin
                        w_rfg_address_next = r_rfg_address + 8'd1;
                    end
                    w_state_next = (r_remaining == 16'd1) ? ST_CSUM : ST_RD_ISSUE;
                end
            end
            ST_CSUM: begin
                if (!fifo_prog_full) begin
                    w_fifo_wr_en_next = 1'b1;
                    w_fifo_din_next   = r_csum;
                    w_state_next      = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Ready rises one cycle after returning to IDLE, which keeps it low in
        // the cycle following the checksum write.
        w_req_ready_next = (r_state == ST_IDLE) && !w_accept;
        w_busy_next      = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b0;
            r_rfg_read    <= 1'b0;
            r_rfg_address <= 8'h00;
            r_fifo_din    <= 8'h00;
            r_fifo_wr_en  <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_incr        <= 1'b0;
            r_length      <= 16'd0;
            r_remaining   <= 16'd0;
            r_csum        <= 8'h00;
            r_data        <= 8'h00;
            r_tmo_cnt     <= 16'd0;
        end else begin
            r_state       <= w_state_next;
            r_req_ready   <= w_req_ready_next;
            r_rfg_read    <= w_rfg_read_next;
            r_rfg_address <= w_rfg_address_next;
            r_fifo_din    <= w_fifo_din_next;
            r_fifo_wr_en  <= w_fifo_wr_en_next;
            r_busy        <= w_busy_next;
            r_timeout_err <= w_timeout_err_next;
            r_incr        <= w_incr_next;
            r_length      <= w_length_next;
            r_remaining   <= w_remaining_next;
            r_csum        <= w_csum_next;
            r_data        <= w_data_next;
            r_tmo_cnt     <= w_tmo_cnt_next;
        end
    end

    assign req_ready   = r_req_ready;
    assign rfg_read    = r_rfg_read;
    assign rfg_address = r_rfg_address;
    assign fifo_din    = r_fifo_din;
    assign fifo_wr_en  = r_fifo_wr_en;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_rfg_readback_framer.sv
// ---------------------------------------------------------------------------
// tb_rfg_readback_framer
// Table of request/expected-frame records applied in a loop, plus a
// hand-written mid-frame reset sequence. A small register-file responder
// answers each rfg_read with rfg_done in the same cycle (zero latency).
// ---------------------------------------------------------------------------
module tb_rfg_readback_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_address = 8'h00;
    logic [15:0] req_length = 16'd0;
    logic        req_incr = 1'b0;
    logic        rfg_read;
    logic [7:0]  rfg_address;
    logic [7:0]  rfg_read_data = 8'h00;
    logic        rfg_done = 1'b0;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        fifo_prog_full = 1'b0;
    logic        busy;
    logic        timeout_err;

    rfg_readback_framer #(.FRAME_HEADER(8'hA5), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_address    (req_address),
        .req_length     (req_length),
        .req_incr       (req_incr),
        .rfg_read       (rfg_read),
        .rfg_address    (rfg_address),
        .rfg_read_data  (rfg_read_data),
        .rfg_done       (rfg_done),
        .fifo_din       (fifo_din),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_prog_full (fifo_prog_full),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Register-file responder
    logic [7:0] resp_data [4];
    int         resp_idx = 0;
    bit         resp_en = 1'b1;
    bit         spur = 1'b0;

    always begin
        @(posedge clk);
        #2;
        if (spur) begin
            rfg_done      = 1'b1;
            rfg_read_data = 8'hEE;
        end else if (rfg_read && resp_en) begin
            rfg_done      = 1'b1;
            rfg_read_data = resp_data[resp_idx % 4];
            resp_idx++;
        end else begin
            rfg_done      = 1'b0;
            rfg_read_data = 8'h00;
        end
    end

    // Capture of FIFO writes and read addresses
    logic [7:0] got_bytes [$];
    logic [7:0] got_addrs [$];

    always @(negedge clk) begin
        if (fifo_wr_en) got_bytes.push_back(fifo_din);
        if (rfg_read)   got_addrs.push_back(rfg_address);
    end

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] len;
        logic        incr;
        logic [7:0]  d [4];
        bit          resp;
        bit          stall;
        bit          spur_hdr;
        int          nb;
        logic [7:0]  exp [8];
        logic [7:0]  ea [4];
        int          cyc;
        logic        terr;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    // Drive one request; returns after the acceptance edge (+1).
    task automatic accept_req(input logic [7:0] a, input logic [15:0] l, input logic inc, output bit ok);
        int w;
        ok = 1'b0;
        @(negedge clk);
        got_bytes.delete();
        got_addrs.delete();
        resp_idx = 0;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            check("req_ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        req_valid   = 1'b1;
        req_address = a;
        req_length  = l;
        req_incr    = inc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        bit ok;
        int n;
        int viol;
        string nm;
        resp_en = v.resp;
        for (int i = 0; i < 4; i++) resp_data[i] = v.d[i];
        accept_req(v.addr, v.len, v.incr, ok);
        if (!ok) return;
        $sformat(nm, "v%0d_terr_clear", idx);
        check(nm, 32'(timeout_err), 32'd0);
        if (v.spur_hdr) spur = 1'b1;
        n = 0;
        viol = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) spur = 1'b0;
            if (v.stall && n == 2) fifo_prog_full = 1'b1;
            if (v.stall && n >= 3 && n <= 12) begin
                if (fifo_wr_en || rfg_read || !busy) viol++;
                if (n == 12) fifo_prog_full = 1'b0;
            end
            if (req_ready) break;
        end
        $sformat(nm, "v%0d_cycles", idx);
        check(nm, 32'(n), 32'(v.cyc));
        if (v.stall) begin
            $sformat(nm, "v%0d_stall_quiet", idx);
            check(nm, 32'(viol), 32'd0);
        end
        $sformat(nm, "v%0d_nbytes", idx);
        check(nm, 32'(got_bytes.size()), 32'(v.nb));
        for (int i = 0; i < v.nb && i < got_bytes.size(); i++) begin
            $sformat(nm, "v%0d_byte%0d", idx, i);
            check(nm, 32'(got_bytes[i]), 32'(v.exp[i]));
        end
        $sformat(nm, "v%0d_nreads", idx);
        check(nm, 32'(got_addrs.size()), 32'(v.len));
        for (int i = 0; i < int'(v.len) && i < got_addrs.size(); i++) begin
            $sformat(nm, "v%0d_raddr%0d", idx, i);
            check(nm, 32'(got_addrs[i]), 32'(v.ea[i]));
        end
        $sformat(nm, "v%0d_terr", idx);
        check(nm, 32'(timeout_err), 32'(v.terr));
        $display("[TB] frame %0d addr=%02h len=%0d incr=%0d bytes=%0d cycles=%0d terr=%0d",
                 idx, v.addr, v.len, v.incr, got_bytes.size(), n, timeout_err);
    endtask

    initial begin
        bit ok;
        vecs[0] = '{8'h21, 16'd2, 1'b0, '{8'h10, 8'h20, 8'h00, 8'h00}, 1'b1, 1'b0, 1'b0, 7,
                    '{8'hA5, 8'h21, 8'h00, 8'h02, 8'h10, 8'h20, 8'h53, 8'h00},
                    '{8'h21, 8'h21, 8'h00, 8'h00}, 12, 1'b0};
        vecs[1] = '{8'h05, 16'd0, 1'b0, '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 1'b0, 5,
                    '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00},
                    '{8'h00, 8'h00, 8'h00, 8'h00}, 6, 1'b0};
        vecs[2] = '{8'hFF, 16'd2, 1'b1, '{8'h11, 8'h22, 8'h00, 8'h00}, 1'b1, 1'b0, 1'b0, 7,
                    '{8'hA5, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h34, 8'h00},
                    '{8'hFF, 8'h00, 8'h00, 8'h00}, 12, 1'b0};
        vecs[3] = '{8'h80, 16'd3, 1'b1, '{8'h01, 8'h02, 8'h03, 8'h00}, 1'b1, 1'b0, 1'b0, 8,
                    '{8'hA5, 8'h80, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h89},
                    '{8'h80, 8'h81, 8'h82, 8'h00}, 15, 1'b0};
        // No rfg_done: 15 extra wait cycles beyond the zero-latency 9.
        vecs[4] = '{8'h30, 16'd1, 1'b0, '{8'h77, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 6,
                    '{8'hA5, 8'h30, 8'h00, 8'h01, 8'h00, 8'h31, 8'h00, 8'h00},
                    '{8'h30, 8'h00, 8'h00, 8'h00}, 24, 1'b1};
        // 10-cycle prog_full stall in LENH plus a spurious rfg_done in HDR.
        vecs[5] = '{8'h42, 16'd1, 1'b0, '{8'h99, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1, 1'b1, 6,
                    '{8'hA5, 8'h42, 8'h00, 8'h01, 8'h99, 8'hDC, 8'h00, 8'h00},
                    '{8'h42, 8'h00, 8'h00, 8'h00}, 19, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_outputs", {rfg_read, rfg_address, fifo_wr_en, fifo_din, busy, timeout_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(req_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_frame(i, vecs[i]);
            if (i == 4) begin
                repeat (5) @(negedge clk);
                check("terr_sticky", 32'(timeout_err), 32'd1);
            end
        end

        // Reset mid-data, then a clean frame.
        resp_en = 1'b1;
        resp_data[0] = 8'h5A; resp_data[1] = 8'h6B; resp_data[2] = 8'h7C; resp_data[3] = 8'h00;
        accept_req(8'h60, 16'd3, 1'b1, ok);
        if (ok) begin
            repeat (8) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check("midrst_req_ready", 32'(req_ready), 32'd0);
            check("midrst_outputs", {rfg_read, rfg_address, fifo_wr_en, fifo_din, busy, timeout_err}, 32'd0);
            check("midrst_partial", 32'(got_bytes.size() > 0 && got_bytes.size() < 8), 32'd1);
            $display("[TB] mid-frame reset after %0d bytes", got_bytes.size());
            @(negedge clk);
            rst = 1'b0;
        end
        run_frame(6, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
